// File: rtl/mbw_pkg.sv
// rtl/mbw_pkg.sv - shared types and helpers for the multi-bank write controller
//
// Contents:
//   state_t        write FSM state encoding (IDLE=0, WRITE=1, COMMIT=2)
//   POPCOUNT_MAX_W widest bank vector the popcount helper accepts
//   popcount()     number of set bits in a zero-extended bank vector
package mbw_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam int unsigned POPCOUNT_MAX_W = 32;

   function automatic int unsigned popcount(input logic [POPCOUNT_MAX_W-1:0] v);
      int unsigned c;
      c = 0;
      for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
         c = c + 32'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/multi_bank_write_ctrl_if.sv
// rtl/multi_bank_write_ctrl_if.sv - source/reader bus of the multi-bank write controller
//
// Signals:
//   din, din_vld   write data and write request from the source
//   r_done         per-bank release pulses from the reader
//   busy           controller is not IDLE
//   w_addr, w_data target bank index and captured write data
//   w_en           one-cycle memory write strobe
//   status_vld     per-bank occupied flags
//   count          number of occupied banks
//   full, empty    all banks occupied / none occupied
//   drop           one-cycle pulse for each rejected request
// Modports:
//   master         source/reader side (drives din, din_vld, r_done)
//   slave          controller side
interface mbw_if #(
   parameter int DATA_W = 8,
   parameter int BANKS  = 4
);
   localparam int ADDR_W = $clog2(BANKS);

   logic [DATA_W-1:0] din;
   logic              din_vld;
   logic [BANKS-1:0]  r_done;
   logic              busy;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic              w_en;
   logic [BANKS-1:0]  status_vld;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              empty;
   logic              drop;

   modport master (
      output din, din_vld, r_done,
      input  busy, w_addr, w_data, w_en, status_vld, count, full, empty, drop
   );

   modport slave (
      input  din, din_vld, r_done,
      output busy, w_addr, w_data, w_en, status_vld, count, full, empty, drop
   );

endinterface

// File: rtl/bank_popcount.sv
// rtl/bank_popcount.sv - occupied-bank counter
//
// Ports:
//   vec  BANKS-bit occupied flags
//   cnt  number of set bits in vec (ADDR_W+1 bits so BANKS itself fits)
module bank_popcount
   import mbw_pkg::*;
#(
   parameter  int BANKS  = 4,
   localparam int ADDR_W = $clog2(BANKS)
) (
   input  logic [BANKS-1:0] vec,
   output logic [ADDR_W:0]  cnt
);

   assign cnt = (ADDR_W+1)'(popcount(POPCOUNT_MAX_W'(vec)));

endmodule

// File: rtl/multi_bank_write_ctrl.sv
// rtl/multi_bank_write_ctrl.sv - ring-ordered write controller for a multi-bank buffer
//
// Ports:
//   clk    single clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    mbw_if.slave: din/din_vld/r_done in; busy, w_addr, w_data, w_en,
//          status_vld, count, full, empty, drop out
// A request accepted in IDLE takes three cycles: IDLE -> WRITE (w_en) -> COMMIT
// (bank marked occupied, ring pointer advanced) -> IDLE. A request aimed at an
// occupied bank is dropped; the pointer never skips ahead on release.
module multi_bank_write_ctrl
   import mbw_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int BANKS  = 4
) (
   input  logic clk,
   input  logic n_rst,
   mbw_if.slave bus
);

   localparam int ADDR_W = $clog2(BANKS);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] w_addr_q;
   logic [DATA_W-1:0] w_data_q;
   logic [BANKS-1:0]  status_q;
   logic [BANKS-1:0]  status_nxt;
   logic [BANKS-1:0]  set_mask;
   logic              drop_q;
   logic              accept;
   logic              reject;
   logic [ADDR_W:0]   count_w;

   // Requests are only looked at in IDLE; while busy they are silently ignored.
   assign accept = (state == IDLE) &&  bus.din_vld && !status_q[w_addr_q];
   assign reject = (state == IDLE) &&  bus.din_vld &&  status_q[w_addr_q];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      set_mask  = '0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = WRITE;
         end
         WRITE: begin
            state_nxt = COMMIT;
         end
         COMMIT: begin
            set_mask  = BANKS'(1) << w_addr_q;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Releases apply every cycle; a release colliding with this cycle's commit
   // on the same bank loses so the freshly written bank is never lost.
   assign status_nxt = (status_q | set_mask) & ~(bus.r_done & ~set_mask);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         w_addr_q <= '0;
         w_data_q <= '0;
         status_q <= '0;
         drop_q   <= 1'b0;
      end else begin
         status_q <= status_nxt;
         drop_q   <= reject;
         if (accept) begin
            w_data_q <= bus.din;
         end
         // BANKS is a power of two, so the natural wrap is the ring wrap.
         if (state == COMMIT) begin
            w_addr_q <= w_addr_q + ADDR_W'(1);
         end
      end
   end

   bank_popcount #(
      .BANKS (BANKS)
   ) u_popcount (
      .vec (status_q),
      .cnt (count_w)
   );

   assign bus.busy       = (state != IDLE);
   assign bus.w_en       = (state == WRITE);
   assign bus.w_addr     = w_addr_q;
   assign bus.w_data     = w_data_q;
   assign bus.status_vld = status_q;
   assign bus.count      = count_w;
   assign bus.full       = &status_q;
   assign bus.empty      = ~|status_q;
   assign bus.drop       = drop_q;

endmodule

// File: tb/tb_multi_bank_write_ctrl.sv
// tb/tb_multi_bank_write_ctrl.sv - directed bench for multi_bank_write_ctrl
module tb_multi_bank_write_ctrl;

   typedef struct {
      logic       n_rst;
      logic [7:0] din;
      logic       din_vld;
      logic [3:0] r_done;
      logic       busy;
      logic       w_en;
      logic [1:0] w_addr;
      logic [7:0] w_data;
      logic [3:0] status;
      logic [2:0] count;
      logic       full;
      logic       empty;
      logic       drop;
   } vec_t;

   logic clk;
   logic n_rst;
   int   n_cmp;
   int   n_fail;
   vec_t tbl[$];

   mbw_if #(.DATA_W(8), .BANKS(4)) bus ();

   multi_bank_write_ctrl #(
      .DATA_W (8),
      .BANKS  (4)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic rst, input logic [7:0] din, input logic vld, input logic [3:0] rd,
      input logic busy, input logic wen, input logic [1:0] addr, input logic [7:0] data,
      input logic [3:0] st, input logic [2:0] cnt, input logic full, input logic empty,
      input logic drop);
      vec_t v;
      v.n_rst = rst;  v.din = din;   v.din_vld = vld; v.r_done = rd;
      v.busy  = busy; v.w_en = wen;  v.w_addr = addr; v.w_data = data;
      v.status = st;  v.count = cnt; v.full = full;   v.empty = empty;
      v.drop  = drop;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic [7:0] din, input logic vld,
                        input logic [3:0] rd);
      @(negedge clk);
      n_rst       = rst;
      bus.din     = din;
      bus.din_vld = vld;
      bus.r_done  = rd;
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 8'h00, 1'b0, 4'h0);
      drive(1'b1, 8'h00, 1'b0, 4'h0);
   endtask

   initial begin
      int wen_cnt;
      int drop_cnt;
      n_cmp  = 0;
      n_fail = 0;
      n_rst       = 1'b0;
      bus.din     = 8'h00;
      bus.din_vld = 1'b0;
      bus.r_done  = 4'h0;
      repeat (2) @(negedge clk);

      //                rst din   vld rd      busy wen addr data  st      cnt full empty drop
      tbl.push_back(mk(0, 8'h00, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 0, 0, 1, 0)); // r0 in reset
      tbl.push_back(mk(1, 8'hA5, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 0, 0, 1, 0)); // r1 request
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 1, 1, 0, 8'hA5, 4'b0000, 0, 0, 1, 0)); // r2 WRITE
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 1, 0, 0, 8'hA5, 4'b0000, 0, 0, 1, 0)); // r3 COMMIT
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 0, 0, 1, 8'hA5, 4'b0001, 1, 0, 0, 0)); // r4 set
      tbl.push_back(mk(0, 8'h00, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 0, 0, 1, 0)); // r5 reset
      tbl.push_back(mk(1, 8'h11, 1, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 0, 0, 1, 0)); // r6
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 1, 1, 0, 8'h11, 4'b0000, 0, 0, 1, 0));
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 1, 0, 0, 8'h11, 4'b0000, 0, 0, 1, 0));
      tbl.push_back(mk(1, 8'h22, 1, 4'b0000, 0, 0, 1, 8'h11, 4'b0001, 1, 0, 0, 0)); // r9
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 1, 1, 1, 8'h22, 4'b0001, 1, 0, 0, 0));
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 1, 0, 1, 8'h22, 4'b0001, 1, 0, 0, 0));
      tbl.push_back(mk(1, 8'h33, 1, 4'b0000, 0, 0, 2, 8'h22, 4'b0011, 2, 0, 0, 0)); // r12
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 1, 1, 2, 8'h33, 4'b0011, 2, 0, 0, 0));
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 1, 0, 2, 8'h33, 4'b0011, 2, 0, 0, 0));
      tbl.push_back(mk(1, 8'h44, 1, 4'b0000, 0, 0, 3, 8'h33, 4'b0111, 3, 0, 0, 0)); // r15
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 1, 1, 3, 8'h44, 4'b0111, 3, 0, 0, 0));
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 1, 0, 3, 8'h44, 4'b0111, 3, 0, 0, 0));
      tbl.push_back(mk(1, 8'h55, 1, 4'b0000, 0, 0, 0, 8'h44, 4'b1111, 4, 1, 0, 0)); // r18 full, 5th
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 0, 0, 0, 8'h44, 4'b1111, 4, 1, 0, 1)); // r19 drop
      tbl.push_back(mk(1, 8'h00, 0, 4'b0101, 0, 0, 0, 8'h44, 4'b1111, 4, 1, 0, 0)); // r20 release
      tbl.push_back(mk(1, 8'h66, 1, 4'b0000, 0, 0, 0, 8'h44, 4'b1010, 2, 0, 0, 0)); // r21
      tbl.push_back(mk(1, 8'h99, 1, 4'b0000, 1, 1, 0, 8'h66, 4'b1010, 2, 0, 0, 0)); // r22 busy req
      tbl.push_back(mk(1, 8'h99, 1, 4'b0000, 1, 0, 0, 8'h66, 4'b1010, 2, 0, 0, 0)); // r23 busy req
      tbl.push_back(mk(1, 8'h00, 0, 4'b0010, 0, 0, 1, 8'h66, 4'b1011, 3, 0, 0, 0)); // r24 no drop
      tbl.push_back(mk(1, 8'h77, 1, 4'b0000, 0, 0, 1, 8'h66, 4'b1001, 2, 0, 0, 0)); // r25
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 1, 1, 1, 8'h77, 4'b1001, 2, 0, 0, 0));
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 1, 0, 1, 8'h77, 4'b1001, 2, 0, 0, 0));
      tbl.push_back(mk(1, 8'h88, 1, 4'b0000, 0, 0, 2, 8'h77, 4'b1011, 3, 0, 0, 0)); // r28
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 1, 1, 2, 8'h88, 4'b1011, 3, 0, 0, 0));
      tbl.push_back(mk(1, 8'h00, 0, 4'b0100, 1, 0, 2, 8'h88, 4'b1011, 3, 0, 0, 0)); // r30 set vs clr
      tbl.push_back(mk(1, 8'h00, 0, 4'b1111, 0, 0, 3, 8'h88, 4'b1111, 4, 1, 0, 0)); // r31 clear all
      tbl.push_back(mk(1, 8'h00, 0, 4'b0101, 0, 0, 3, 8'h88, 4'b0000, 0, 0, 1, 0)); // r32 on clear
      tbl.push_back(mk(1, 8'h00, 0, 4'b0000, 0, 0, 3, 8'h88, 4'b0000, 0, 0, 1, 0)); // r33

      foreach (tbl[i]) begin
         drive(tbl[i].n_rst, tbl[i].din, tbl[i].din_vld, tbl[i].r_done);
         check($sformatf("row%0d.busy", i),   32'(bus.busy),       32'(tbl[i].busy));
         check($sformatf("row%0d.w_en", i),   32'(bus.w_en),       32'(tbl[i].w_en));
         check($sformatf("row%0d.w_addr", i), 32'(bus.w_addr),     32'(tbl[i].w_addr));
         check($sformatf("row%0d.w_data", i), 32'(bus.w_data),     32'(tbl[i].w_data));
         check($sformatf("row%0d.status", i), 32'(bus.status_vld), 32'(tbl[i].status));
         check($sformatf("row%0d.count", i),  32'(bus.count),      32'(tbl[i].count));
         check($sformatf("row%0d.full", i),   32'(bus.full),       32'(tbl[i].full));
         check($sformatf("row%0d.empty", i),  32'(bus.empty),      32'(tbl[i].empty));
         check($sformatf("row%0d.drop", i),   32'(bus.drop),       32'(tbl[i].drop));
      end

      // Reset asserted while in WRITE.
      do_reset();
      drive(1'b1, 8'h5A, 1'b1, 4'h0);
      drive(1'b1, 8'h00, 1'b0, 4'h0);
      check("rstw.pre_w_en", 32'(bus.w_en), 32'd1);
      drive(1'b0, 8'h00, 1'b0, 4'h0);
      check("rstw.busy",   32'(bus.busy),       32'd0);
      check("rstw.w_en",   32'(bus.w_en),       32'd0);
      check("rstw.w_addr", 32'(bus.w_addr),     32'd0);
      check("rstw.status", 32'(bus.status_vld), 32'd0);
      check("rstw.empty",  32'(bus.empty),      32'd1);
      drive(1'b1, 8'h00, 1'b0, 4'h0);
      repeat (3) drive(1'b1, 8'h00, 1'b0, 4'h0);
      check("rstw.after_status", 32'(bus.status_vld), 32'd0);
      check("rstw.after_addr",   32'(bus.w_addr),     32'd0);

      // Reset asserted while in COMMIT.
      drive(1'b1, 8'h5A, 1'b1, 4'h0);
      drive(1'b1, 8'h00, 1'b0, 4'h0);
      drive(1'b1, 8'h00, 1'b0, 4'h0);
      check("rstc.pre_busy", 32'(bus.busy), 32'd1);
      drive(1'b0, 8'h00, 1'b0, 4'h0);
      drive(1'b1, 8'h00, 1'b0, 4'h0);
      repeat (3) drive(1'b1, 8'h00, 1'b0, 4'h0);
      check("rstc.status", 32'(bus.status_vld), 32'd0);
      check("rstc.w_addr", 32'(bus.w_addr),     32'd0);
      check("rstc.empty",  32'(bus.empty),      32'd1);

      // din_vld held high for six cycles: writes land in cycles 1 and 4 only.
      do_reset();
      wen_cnt  = 0;
      drop_cnt = 0;
      for (int c = 0; c < 9; c++) begin
         drive(1'b1, 8'(c + 1), (c < 6) ? 1'b1 : 1'b0, 4'h0);
         check($sformatf("hold.w_en.c%0d", c), 32'(bus.w_en), (c == 1 || c == 4) ? 32'd1 : 32'd0);
         check($sformatf("hold.drop.c%0d", c), 32'(bus.drop), 32'd0);
         if (bus.w_en === 1'b1) wen_cnt++;
         if (bus.drop === 1'b1) drop_cnt++;
      end
      check("hold.writes", 32'(wen_cnt),  32'd2);
      check("hold.drops",  32'(drop_cnt), 32'd0);
      check("hold.status", 32'(bus.status_vld), 32'b0011);
      check("hold.w_addr", 32'(bus.w_addr),     32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_bank_write_ctrl.md
MULTI_BANK_WRITE_CTRL -- requirements
Module: multi_bank_write_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, write-data width in bits.
REQ-002 SHALL have parameter BANKS, default 4, number of buffer banks; legal values are powers of 2, at least 2.
REQ-003 SHALL derive localparam ADDR_W = clog2(BANKS), the bank index width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port din, input, DATA_W, write data from the source.
REQ-007 SHALL have port din_vld, input, 1, write request; sampled only in IDLE.
REQ-008 SHALL have port r_done, input, BANKS, per-bank release pulses from the reader.
REQ-009 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 SHALL have port w_addr, output, ADDR_W, the current target bank index.
REQ-011 SHALL have port w_data, output, DATA_W, registered copy of the captured din.
REQ-012 SHALL have port w_en, output, 1, memory write strobe.
REQ-013 SHALL have port status_vld, output, BANKS, per-bank occupied flags.
REQ-014 SHALL have port count, output, ADDR_W+1, number of occupied banks.
REQ-015 SHALL have ports full and empty, each output, 1.
REQ-016 SHALL have port drop, output, 1, one-cycle pulse on each rejected request.

Function
REQ-017 SHALL implement the FSM states IDLE, WRITE and COMMIT.
REQ-018 SHALL, in IDLE with din_vld=1 and status_vld[w_addr]=0, capture din into w_data and go to WRITE next cycle.
REQ-019 SHALL, in IDLE with din_vld=1 and status_vld[w_addr]=1, stay in IDLE, assert drop for the next cycle, and discard the data.
REQ-020 SHALL assert w_en=1 for exactly the one WRITE cycle, with w_addr and w_data stable, then go to COMMIT.
REQ-021 SHALL, in COMMIT, set status_vld[w_addr] and increment w_addr modulo BANKS (BANKS-1 wraps to 0); both are visible the next cycle, when the FSM returns to IDLE.
REQ-022 SHALL give a latency, from din_vld sampled in cycle n, of w_en in cycle n+1 and the status bit set in cycle n+3; maximum throughput is one write per 3 cycles.
REQ-023 SHALL ignore din_vld while busy=1, with no drop pulse.
REQ-024 SHALL apply r_done in every state and every cycle: status_next = (status_vld | set_mask) & ~(r_done & ~set_mask).
REQ-025 SHALL let the set win when a COMMIT set and an r_done clear hit the same bank in the same cycle.
REQ-026 SHALL ignore r_done bits for banks already clear, and SHALL apply several r_done bits in one cycle together.
REQ-027 SHALL drive count as the combinational popcount of status_vld, full=1 only when all bits are set, and empty=1 only when all bits are clear.
REQ-028 SHALL not advance w_addr on release; banks fill strictly in ring order.

Reset
REQ-029 SHALL, on n_rst=0, asynchronously force state=IDLE, w_addr=0, w_data=0, status_vld=0 and drop=0.
REQ-030 SHALL hold w_en=0, busy=0, count=0, full=0 and empty=1 during reset.
REQ-031 SHALL abandon any in-flight write on reset mid-WRITE or mid-COMMIT, leaving no status bit set.

Structure
REQ-032 SHALL place the state encoding (IDLE=0, WRITE=1, COMMIT=2, 2-bit) in shared package mbw_pkg.
REQ-033 SHALL place a popcount helper function in mbw_pkg.
REQ-034 SHALL implement count through one sub-module, bank_popcount, parametrised by BANKS.

Verification (BANKS=4, DATA_W=8)
REQ-035 SHALL check: after reset, din=0xA5 with din_vld for 1 cycle -> w_en in cycle 1 with w_addr=0, w_data=0xA5; status_vld=0001, count=1, w_addr=1 in cycle 3.
REQ-036 SHALL check: 4 writes 0x11..0x44 then a 5th request -> status_vld=1111, full=1, w_addr=0 after wrap, 5th gives drop=1 with no w_en.
REQ-037 SHALL check: from full, r_done=0101 for 1 cycle -> status_vld=1010, count=2, full=0.
REQ-038 SHALL check: COMMIT to bank 2 with r_done=0100 in the same cycle -> status_vld[2]=1.
REQ-039 SHALL check: n_rst pulse during WRITE -> IDLE, status_vld=0, w_addr=0, w_en=0, empty=1.
REQ-040 SHALL check: din_vld held high for 6 cycles from IDLE -> exactly 2 writes (cycles 1 and 4), no drop.
